// File: rtl/vend_change_dispenser_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vend_pkg
// Desc    : Coin encodings, denomination values and FSM state type shared by
//           the change dispenser and its greedy coin selector.
// Rev     : 1.0  initial release
// ============================================================================
package vend_pkg;

    localparam logic [1:0] c_COIN_1  = 2'b00;
    localparam logic [1:0] c_COIN_5  = 2'b01;
    localparam logic [1:0] c_COIN_10 = 2'b10;
    localparam logic [1:0] c_COIN_20 = 2'b11;

    localparam logic [4:0] c_VAL_1  = 5'd1;
    localparam logic [4:0] c_VAL_5  = 5'd5;
    localparam logic [4:0] c_VAL_10 = 5'd10;
    localparam logic [4:0] c_VAL_20 = 5'd20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [4:0] coin_value(input logic [1:0] ct);
        logic [4:0] v;
        case (ct)
            c_COIN_1:  v = c_VAL_1;
            c_COIN_5:  v = c_VAL_5;
            c_COIN_10: v = c_VAL_10;
            default:   v = c_VAL_20;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_change_dispenser_coin_select.sv
`default_nettype none
// ============================================================================
// Module  : vend_coin_select
// Desc    : Greedy selector - largest available denomination not exceeding the
//           amount still owed. avail_mask is indexed by coin_type encoding.
// Rev     : 1.0  initial release
// ============================================================================
module vend_coin_select
    import vend_pkg::*;
(
    input  logic [4:0] remaining,
    input  logic [3:0] avail_mask,
    output logic [1:0] coin_type,
    output logic       valid
);

    always_comb begin
        coin_type = c_COIN_1;
        valid     = 1'b0;
        if (avail_mask[c_COIN_20] && (remaining >= c_VAL_20)) begin
            coin_type = c_COIN_20;
            valid     = 1'b1;
        end else if (avail_mask[c_COIN_10] && (remaining >= c_VAL_10)) begin
            coin_type = c_COIN_10;
            valid     = 1'b1;
        end else if (avail_mask[c_COIN_5] && (remaining >= c_VAL_5)) begin
            coin_type = c_COIN_5;
            valid     = 1'b1;
        end else if (avail_mask[c_COIN_1] && (remaining >= c_VAL_1)) begin
            coin_type = c_COIN_1;
            valid     = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vend_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module  : vend_change_dispenser
// Desc    : Pays out requested change one coin at a time through a hopper
//           handshake. Define VEND_COIN_INVENTORY_EN for per-coin stock counts.
// Rev     : 1.0  initial release
// ============================================================================
module vend_change_dispenser
    import vend_pkg::*;
`ifdef VEND_COIN_INVENTORY_EN
#(
    parameter logic [3:0] INV_INIT = 4'd8
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic       change_valid,
    input  logic [4:0] change_amount,
    output logic       change_ready,
    output logic       coin_req,
    output logic [1:0] coin_type,
    input  logic       coin_ack,
    output logic       busy,
    output logic       done,
`ifdef VEND_COIN_INVENTORY_EN
    input  logic       refill,
    input  logic [1:0] refill_type,
    output logic       short,
`endif
    output logic [4:0] remaining
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_remaining;
    logic [4:0] w_remaining_nxt;
    logic [3:0] w_avail;
    logic [1:0] w_sel_type;
    logic       w_sel_valid;
    logic       w_ack_fire;

    vend_coin_select u_coin_select (
        .remaining  (r_remaining),
        .avail_mask (w_avail),
        .coin_type  (w_sel_type),
        .valid      (w_sel_valid)
    );

    assign change_ready = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DONE);
    assign coin_req     = (r_state == ST_ISSUE) && w_sel_valid;
    assign coin_type    = coin_req ? w_sel_type : c_COIN_1;
    assign remaining    = r_remaining;
    assign w_ack_fire   = coin_req && coin_ack;

`ifdef VEND_COIN_INVENTORY_EN
    logic r_short;
    logic w_short_nxt;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_inv
            logic [3:0] r_cnt;
            logic       w_inc;
            logic       w_dec;

            assign w_inc = refill && (refill_type == 2'(gi));
            assign w_dec = w_ack_fire && (w_sel_type == 2'(gi));

            // Refill and dispense of the same type in one cycle cancel out.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt <= INV_INIT;
                end else if (w_inc && !w_dec && (r_cnt != 4'd15)) begin
                    r_cnt <= r_cnt + 4'd1;
                end else if (w_dec && !w_inc) begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end

            assign w_avail[gi] = (r_cnt != 4'd0);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_short <= 1'b0;
        end else begin
            r_short <= w_short_nxt;
        end
    end

    assign short = (r_state == ST_DONE) && r_short;
`else
    assign w_avail = 4'hF;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= 5'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
`ifdef VEND_COIN_INVENTORY_EN
        w_short_nxt     = r_short;
`endif
        case (r_state)
            ST_IDLE: begin
                if (change_valid) begin
                    w_remaining_nxt = change_amount;
                    w_state_nxt     = (change_amount != 5'd0) ? ST_ISSUE : ST_DONE;
`ifdef VEND_COIN_INVENTORY_EN
                    w_short_nxt     = 1'b0;
`endif
                end
            end
            ST_ISSUE: begin
                // No eligible coin only arises when stock runs out; the owed
                // amount is kept so the host can see the shortfall.
                if (!w_sel_valid) begin
                    w_state_nxt = ST_DONE;
`ifdef VEND_COIN_INVENTORY_EN
                    w_short_nxt = 1'b1;
`endif
                end else if (w_ack_fire) begin
                    w_remaining_nxt = r_remaining - coin_value(w_sel_type);
                    if (w_remaining_nxt == 5'd0) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_vend_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module  : tb_vend_change_dispenser
// Desc    : Randomized bench for vend_change_dispenser against a greedy
//           payout reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_vend_change_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       change_valid;
    logic [4:0] change_amount;
    logic       change_ready;
    logic       coin_req;
    logic [1:0] coin_type;
    logic       coin_ack;
    logic       busy;
    logic       done;
    logic [4:0] remaining;
`ifdef VEND_COIN_INVENTORY_EN
    logic       refill;
    logic [1:0] refill_type;
    logic       short;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int m_inv [4];

    vend_change_dispenser dut (
        .clk           (clk),
        .reset         (reset),
        .change_valid  (change_valid),
        .change_amount (change_amount),
        .change_ready  (change_ready),
        .coin_req      (coin_req),
        .coin_type     (coin_type),
        .coin_ack      (coin_ack),
        .busy          (busy),
        .done          (done),
`ifdef VEND_COIN_INVENTORY_EN
        .refill        (refill),
        .refill_type   (refill_type),
        .short         (short),
`endif
        .remaining     (remaining)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int code_of(input int v);
        case (v)
            1:       return 0;
            5:       return 1;
            10:      return 2;
            default: return 3;
        endcase
    endfunction

    function automatic bit in_stock(input int v);
`ifdef VEND_COIN_INVENTORY_EN
        return m_inv[code_of(v)] > 0;
`else
        return (v > 0);
`endif
    endfunction

    function automatic int pick(input int rem);
        int vals [4];
        vals = '{20, 10, 5, 1};
        foreach (vals[i]) begin
            if (vals[i] <= rem && in_stock(vals[i])) return vals[i];
        end
        return 0;
    endfunction

    // One complete change request: greedy plan first, then drive the hopper.
    task automatic do_req(input int amt, input int dmin, input int dmax);
        int q [$];
        int rem;
        int d;
        bit shrt;
        rem  = amt;
        shrt = 1'b0;
        while (rem > 0) begin
            int c;
            c = pick(rem);
            if (c == 0) begin
                shrt = 1'b1;
                break;
            end
            q.push_back(c);
            rem -= c;
`ifdef VEND_COIN_INVENTORY_EN
            m_inv[code_of(c)]--;
`endif
        end

        chk("ready_before_req", change_ready, 1);
        change_valid  = 1'b1;
        change_amount = 5'(amt);
        coin_ack      = 1'b0;
        tick();
        change_valid  = 1'b0;
        rem = amt;

        foreach (q[k]) begin
            chk("coin_req", coin_req, 1);
            chk("coin_type", coin_type, code_of(q[k]));
            chk("busy_issue", busy, 1);
            chk("ready_issue", change_ready, 0);
            chk("remaining_issue", remaining, rem);
            d = $urandom_range(dmax, dmin);
            repeat (d) begin
                change_valid  = 1'($urandom_range(1, 0));
                change_amount = 5'($urandom);
                tick();
                chk("coin_req_hold", coin_req, 1);
                chk("coin_type_hold", coin_type, code_of(q[k]));
                chk("remaining_hold", remaining, rem);
                chk("done_hold", done, 0);
            end
            change_valid = 1'b0;
            coin_ack     = 1'b1;
            tick();
            coin_ack = 1'b0;
            rem -= q[k];
        end

        if (shrt) begin
            chk("short_no_coin_req", coin_req, 0);
            chk("short_busy", busy, 1);
            tick();
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_ready", change_ready, 0);
        chk("done_coin_req", coin_req, 0);
        chk("done_remaining", remaining, rem);
`ifdef VEND_COIN_INVENTORY_EN
        chk("done_short", short, shrt);
`endif
        tick();
        chk("done_width", done, 0);
        chk("ready_after", change_ready, 1);
        chk("busy_after", busy, 0);
        chk("remaining_after", remaining, rem);
    endtask

    task automatic model_reset();
        foreach (m_inv[i]) m_inv[i] = 8;
    endtask

    initial begin
        #3_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        reset         = 1'b1;
        change_valid  = 1'b0;
        change_amount = 5'd0;
        coin_ack      = 1'b0;
`ifdef VEND_COIN_INVENTORY_EN
        refill        = 1'b0;
        refill_type   = 2'd0;
`endif
        model_reset();
        repeat (2) tick();
        chk("rst_ready", change_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_coin_req", coin_req, 0);
        chk("rst_coin_type", coin_type, 0);
        chk("rst_done", done, 0);
        chk("rst_remaining", remaining, 0);
        reset = 1'b0;
        tick();

        do_req(17, 0, 0);
        do_req(31, 0, 2);
        do_req(0, 0, 0);
        do_req(25, 6, 6);

        // Ack with no coin request outstanding has no effect.
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        chk("idle_ack_remaining", remaining, 0);
        chk("idle_ack_coin_req", coin_req, 0);
        chk("idle_ack_ready", change_ready, 1);

        // Abort 15 after its first coin.
        change_valid  = 1'b1;
        change_amount = 5'd15;
        tick();
        change_valid = 1'b0;
        chk("abort_first_type", coin_type, 2);
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        chk("abort_mid_remaining", remaining, 5);
        chk("abort_mid_type", coin_type, 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_coin_req", coin_req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_remaining", remaining, 0);
        chk("abort_ready", change_ready, 1);
        chk("abort_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) begin
            tick();
            chk("abort_no_done", done, 0);
        end

`ifdef VEND_COIN_INVENTORY_EN
        repeat (8) do_req(10, 0, 1);
        do_req(15, 0, 1);
        for (int n = 0; n < 200; n++) begin
            if (m_inv[0] + m_inv[1] + m_inv[2] + m_inv[3] == 0) break;
            do_req(31, 0, 0);
        end
        do_req(7, 0, 0);
        refill      = 1'b1;
        refill_type = 2'd2;
        tick();
        refill = 1'b0;
        m_inv[2]++;
        do_req(10, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        tick();
`endif

        for (int n = 0; n < 40; n++) begin
            do_req($urandom_range(31, 0), 0, 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
